// File: rtl/tick_timer.sv
// Start/stop tick timer with periodic and one-shot modes and a registered done pulse.
// Define TICK_TIMER_PRESCALE_EN to add the prescaler stage and the prescale port.
module tick_timer #(
  parameter int BITS    = 16,
  parameter int PS_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [BITS-1:0]    final_value,
`ifdef TICK_TIMER_PRESCALE_EN
  input  logic [PS_BITS-1:0] prescale,
`endif
  output logic [BITS-1:0]    count,
  output logic               done,
  output logic               busy
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  if (BITS < 1 || PS_BITS < 1) begin : g_bad_params
    $error("tick_timer: BITS and PS_BITS must be at least 1");
  end

  state_e          state_q, state_d;
  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] shadow_f_q, shadow_f_d;
  logic            shadow_mode_q, shadow_mode_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            step;

`ifdef TICK_TIMER_PRESCALE_EN
  logic [PS_BITS-1:0] ps_q, ps_d;
  logic [PS_BITS-1:0] shadow_p_q, shadow_p_d;

  assign step = (state_q == S_RUN) && enable && (ps_q == shadow_p_q);
`else
  assign step = (state_q == S_RUN) && enable;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shadow_f_d    = shadow_f_q;
    shadow_mode_d = shadow_mode_q;
    done_d        = 1'b0;
`ifdef TICK_TIMER_PRESCALE_EN
    ps_d          = ps_q;
    shadow_p_d    = shadow_p_q;
`endif

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      // A start always wins, including over a coincident terminal step.
      state_d       = S_RUN;
      count_d       = '0;
      shadow_f_d    = final_value;
      shadow_mode_d = mode;
`ifdef TICK_TIMER_PRESCALE_EN
      ps_d          = '0;
      shadow_p_d    = prescale;
`endif
    end else if (step) begin
`ifdef TICK_TIMER_PRESCALE_EN
      ps_d = '0;
`endif
      if (count_q == shadow_f_q) begin
        count_d = '0;
        done_d  = 1'b1;
        if (shadow_mode_q) begin
          state_d = S_IDLE;
        end else begin
          shadow_f_d = final_value;
`ifdef TICK_TIMER_PRESCALE_EN
          shadow_p_d = prescale;
`endif
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
`ifdef TICK_TIMER_PRESCALE_EN
    else if ((state_q == S_RUN) && enable) begin
      ps_d = ps_q + 1'b1;
    end
`endif

    busy_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      shadow_f_q    <= '0;
      shadow_mode_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shadow_f_q    <= shadow_f_d;
      shadow_mode_q <= shadow_mode_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

`ifdef TICK_TIMER_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q       <= '0;
      shadow_p_q <= '0;
    end else begin
      ps_q       <= ps_d;
      shadow_p_q <= shadow_p_d;
    end
  end
`endif

  assign count = count_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed timing scenarios plus randomized traffic
// against a behavioural model. Prescaler scenarios run when TICK_TIMER_PRESCALE_EN is defined.
`timescale 1ns/1ps
module tb_tick_timer;

  localparam int BITS    = 16;
  localparam int PS_BITS = 8;

  logic               clk = 1'b0;
  logic               reset, enable, start, stop, mode;
  logic [BITS-1:0]    final_value;
  logic [PS_BITS-1:0] prescale;
  logic [BITS-1:0]    count;
  logic               done, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tick_timer #(.BITS(BITS), .PS_BITS(PS_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .final_value (final_value),
`ifdef TICK_TIMER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .done        (done),
    .busy        (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs of the new cycle are stable on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b1; mode = 1'b0;
    final_value = '0; prescale = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0; enable = 1'b1; mode = 1'b0;
    final_value = 16'd3; prescale = '0;
    repeat (3) tick();
    tests_run++;
    if (count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_periodic();
    logic [BITS-1:0] exp_c;
    logic            exp_d;
    do_reset();
    final_value = 16'd3; mode = 1'b0; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
      exp_c = 16'((c - 1) % 4);
      exp_d = (c == 5) || (c == 9) || (c == 13);
      tests_run++;
      if (count !== exp_c) begin tests_failed++; $display("FAIL periodic_count c%0d: got %0d want %0d", c, count, exp_c); end
      tests_run++;
      if (done !== exp_d) begin tests_failed++; $display("FAIL periodic_done c%0d: got %b want %b", c, done, exp_d); end
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL periodic_busy c%0d: got %b want 1", c, busy); end
    end
  endtask

  task automatic test_oneshot();
    logic [BITS-1:0] exp_c;
    logic            exp_d, exp_b;
    do_reset();
    final_value = 16'd2; mode = 1'b1; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      exp_c = (c <= 3) ? 16'(c - 1) : 16'd0;
      exp_d = (c == 4);
      exp_b = (c <= 3);
      tests_run++;
      if (count !== exp_c) begin tests_failed++; $display("FAIL oneshot_count c%0d: got %0d want %0d", c, count, exp_c); end
      tests_run++;
      if (done !== exp_d) begin tests_failed++; $display("FAIL oneshot_done c%0d: got %b want %b", c, done, exp_d); end
      tests_run++;
      if (busy !== exp_b) begin tests_failed++; $display("FAIL oneshot_busy c%0d: got %b want %b", c, busy, exp_b); end
    end
  endtask

  task automatic test_reload();
    logic exp_d;
    do_reset();
    final_value = 16'd3; mode = 1'b0; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      exp_d = (c == 5) || (c == 9) || (c == 11) || (c == 13);
      tests_run++;
      if (done !== exp_d) begin tests_failed++; $display("FAIL reload_done c%0d: got %b want %b", c, done, exp_d); end
      if (c == 6) final_value = 16'd1;
    end
  endtask

  task automatic test_enable_gap();
    logic [BITS-1:0] exp_c;
    logic            exp_d;
    do_reset();
    final_value = 16'd3; mode = 1'b0; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start  = 1'b0;
      enable = !(c >= 2 && c <= 4);
      case (c)
        1:       exp_c = 16'd0;
        6:       exp_c = 16'd2;
        7:       exp_c = 16'd3;
        8:       exp_c = 16'd0;
        default: exp_c = 16'd1;
      endcase
      exp_d = (c == 8);
      tests_run++;
      if (count !== exp_c) begin tests_failed++; $display("FAIL enable_gap_count c%0d: got %0d want %0d", c, count, exp_c); end
      tests_run++;
      if (done !== exp_d) begin tests_failed++; $display("FAIL enable_gap_done c%0d: got %b want %b", c, done, exp_d); end
    end
  endtask

  task automatic test_stop_reset();
    do_reset();
    final_value = 16'd5; mode = 1'b0; enable = 1'b1; start = 1'b1;
    tick(); start = 1'b0;            // c1: count 0
    tick();                          // c2: count 1
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy: got %b want 0", busy); end
    tests_run++;
    if (count !== 16'd1) begin tests_failed++; $display("FAIL stop_count_hold: got %0d want 1", count); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL stop_done: got %b want 0", done); end
    tick();
    tests_run++;
    if (count !== 16'd1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_hold: got count %0d busy %b want 1 0", count, busy);
    end
    start = 1'b1;
    tick(); start = 1'b0;            // count 0
    tick();                          // count 1
    tick();                          // count 2
    tests_run++;
    if (count !== 16'd2) begin tests_failed++; $display("FAIL midcount_pre: got %0d want 2", count); end
    reset = 1'b1;
    tick(); reset = 1'b0;
    tests_run++;
    if (count !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midcount_reset: got count %0d done %b busy %b want 0 0 0", count, done, busy);
    end
  endtask

  task automatic test_restart_at_terminal();
    do_reset();
    final_value = 16'd1; mode = 1'b0; enable = 1'b1; start = 1'b1;
    tick(); start = 1'b0;            // c1: count 0
    tick();                          // c2: count 1, terminal step this cycle
    start = 1'b1;
    tick(); start = 1'b0;            // c3
    tests_run++;
    if (count !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL restart_terminal: got count %0d done %b busy %b want 0 0 1", count, done, busy);
    end
    tick();                          // c4: count 1
    tick();                          // c5: done
    tests_run++;
    if (done !== 1'b1 || count !== 16'd0) begin
      tests_failed++; $display("FAIL restart_period: got done %b count %0d want 1 0", done, count);
    end
  endtask

  task automatic test_f_zero();
    do_reset();
    final_value = 16'd0; mode = 1'b0; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      tests_run++;
      if (count !== 16'd0 || done !== (c >= 2) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL f_zero c%0d: got count %0d done %b busy %b want 0 %b 1", c, count, done, busy, (c >= 2));
      end
    end
  endtask

`ifdef TICK_TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic [BITS-1:0] exp_c;
    logic            exp_d;
    do_reset();
    final_value = 16'd1; prescale = 8'd1; mode = 1'b0; enable = 1'b1; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
      exp_c = 16'(((c - 1) / 2) % 2);
      exp_d = (c == 5) || (c == 9) || (c == 13);
      tests_run++;
      if (count !== exp_c) begin tests_failed++; $display("FAIL prescale_count c%0d: got %0d want %0d", c, count, exp_c); end
      tests_run++;
      if (done !== exp_d) begin tests_failed++; $display("FAIL prescale_done c%0d: got %b want %b", c, done, exp_d); end
    end
  endtask
`endif

  // Reference model: timer described by its observable rules, updated once per cycle.
  task automatic test_random();
    logic            m_run, m_oneshot, m_done;
    logic [BITS-1:0] m_count, m_f;
    int              m_p, m_wait;
    m_run = 1'b0; m_oneshot = 1'b0; m_done = 1'b0;
    m_count = '0; m_f = '0; m_p = 0; m_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      reset       = (i == 0) || ($urandom_range(63) == 0);
      start       = ($urandom_range(15) == 0);
      stop        = ($urandom_range(31) == 0);
      enable      = ($urandom_range(3) != 0);
      mode        = 1'($urandom_range(1));
      final_value = 16'($urandom_range(7));
`ifdef TICK_TIMER_PRESCALE_EN
      prescale    = 8'($urandom_range(3));
`else
      prescale    = '0;
`endif
      m_done = 1'b0;
      if (reset) begin
        m_run = 1'b0; m_oneshot = 1'b0; m_count = '0; m_f = '0; m_p = 0; m_wait = 0;
      end else if (stop) begin
        m_run = 1'b0;
      end else if (start) begin
        m_run = 1'b1; m_count = '0; m_wait = 0;
        m_f = final_value; m_oneshot = mode; m_p = int'(prescale);
      end else if (m_run && enable) begin
        if (m_wait < m_p) begin
          m_wait++;
        end else begin
          m_wait = 0;
          if (m_count == m_f) begin
            m_count = '0;
            m_done  = 1'b1;
            if (m_oneshot) m_run = 1'b0;
            else begin m_f = final_value; m_p = int'(prescale); end
          end else begin
            m_count = m_count + 16'd1;
          end
        end
      end
      tick();
      tests_run++;
      if (count !== m_count || done !== m_done || busy !== m_run) begin
        tests_failed++;
        $display("FAIL random i%0d: got count %0d done %b busy %b want %0d %b %b",
                 i, count, done, busy, m_count, m_done, m_run);
      end
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_reload();
    test_enable_gap();
    test_stop_reset();
    test_restart_at_terminal();
    test_f_zero();
`ifdef TICK_TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
